// File: rtl/audio_pkg.sv
// Shared audio-path types and widths used by the I2S front end and the
// downstream filters.
package audio_pkg;

  localparam int AUDIO_SAMPLE_W = 16;

  typedef enum logic [1:0] {
    WAIT_WS,
    SHIFT,
    HOLD
  } i2s_rx_state_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous input.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: synchronizes the bus into clk, deserializes MSB-first words and
// presents a held signed sample plus a per-word toggle strobe.
module i2s_rx_deserializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = AUDIO_SAMPLE_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i2s_bclk,
  input  logic                i2s_ws,
  input  logic                i2s_sd,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_right,
  output logic                sample_valid,
  output logic                lr_toggle,
  output logic                frame_err
);

  localparam int NUM_PINS = 3;
  localparam int CNT_W    = $clog2(SAMPLE_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_W - 1);

  logic [NUM_PINS-1:0] pin, sync;
  logic bclk_s, ws_s, sd_s;

  assign pin = {i2s_sd, i2s_ws, i2s_bclk};

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_sync
    bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (pin[i]),
      .q    (sync[i])
    );
  end

  assign bclk_s = sync[0];
  assign ws_s   = sync[1];
  assign sd_s   = sync[2];

  logic bclk_q, ws_prev;
  logic bclk_rise, ws_chg;

  assign bclk_rise = bclk_s & ~bclk_q;
  assign ws_chg    = ws_s ^ ws_prev;

  i2s_rx_state_t       state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [SAMPLE_W-1:0] shreg, shreg_n, word;
  logic [SAMPLE_W-1:0] out_n;
  logic                chan, chan_n;
  logic                right_n, valid_n, lr_n, err_n;

  assign word = {shreg[SAMPLE_W-2:0], sd_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_WS;
      cnt          <= '0;
      shreg        <= '0;
      chan         <= 1'b0;
      bclk_q       <= 1'b0;
      ws_prev      <= 1'b0;
      sample_out   <= '0;
      sample_right <= 1'b0;
      sample_valid <= 1'b0;
      lr_toggle    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      shreg        <= shreg_n;
      chan         <= chan_n;
      bclk_q       <= bclk_s;
      if (bclk_rise) ws_prev <= ws_s;
      sample_out   <= out_n;
      sample_right <= right_n;
      sample_valid <= valid_n;
      lr_toggle    <= lr_n;
      frame_err    <= err_n;
    end
  end

  // The bit sampled on a ws-change rise is the previous word's LSB; the new
  // word's MSB arrives on the following rise, so the change rise never shifts.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    chan_n  = chan;
    out_n   = sample_out;
    right_n = sample_right;
    valid_n = 1'b0;
    lr_n    = lr_toggle;
    err_n   = 1'b0;
    if (bclk_rise) begin
      case (state)
        WAIT_WS, HOLD: begin
          if (ws_chg) begin
            chan_n  = ws_s;
            cnt_n   = '0;
            state_n = SHIFT;
          end
        end
        SHIFT: begin
          if (ws_chg) begin
            err_n   = 1'b1;
            chan_n  = ws_s;
            cnt_n   = '0;
            shreg_n = '0;
          end else begin
            shreg_n = word;
            if (cnt == LAST) begin
              out_n   = word;
              right_n = chan;
              valid_n = 1'b1;
              lr_n    = ~lr_toggle;
              cnt_n   = '0;
              state_n = HOLD;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
        end
        default: state_n = WAIT_WS;
      endcase
    end
  end

endmodule

// File: doc/i2s_rx_deserializer.md
# i2s_rx_deserializer

Front-end stage of the audio path: samples an external I2S bus (bit clock, word select, serial data) with the system clock, deserializes each channel word, and presents a stable signed sample plus a channel-toggle strobe. The strobe feeds the biquad filter's `l_r_clk` input and `sample_out` feeds its `latest_sample` input. The filter captures a sample on any edge of that strobe.

## Interface
Parameters:
- `SAMPLE_W`, 16: captured word width (MSB-first, two's complement).
- `SYNC_STAGES`, 2: flops in each input synchronizer (≥2).

Ports:
- `clk`  in  1  system clock; must run ≥ 8× bclk.
- `reset`  in  1  synchronous, active-high reset.
- `i2s_bclk`  in  1  asynchronous I2S bit clock.
- `i2s_ws`  in  1  asynchronous word select (0 = left, 1 = right).
- `i2s_sd`  in  1  asynchronous serial data.
- `sample_out`  out  SAMPLE_W  last completed word, signed; held until the next word completes.
- `sample_right`  out  1  channel of `sample_out` (1 = right).
- `sample_valid`  out  1  one-cycle pulse when `sample_out` updates.
- `lr_toggle`  out  1  inverts on every completed word; drives the filter's `l_r_clk`.
- `frame_err`  out  1  one-cycle pulse when a word is truncated by an early ws change.

## Operation
- Synchronizers:
  - `i2s_bclk`, `i2s_ws` and `i2s_sd` each pass through `SYNC_STAGES` flops.
  - `bclk_rise` = synchronized bclk high AND its previous registered value low.
  - All bus sampling occurs only in cycles where `bclk_rise` = 1.
- `ws_prev` register holds ws from the previous bclk rise. A ws change is ws_s ≠ ws_prev at a bclk rise.
- State machine:
  - WAIT_WS (reset state):
    - Ignores data bits.
    - On a ws change: capture `chan` ← ws_s, clear bit count, go to SHIFT.
    - Per I2S, the MSB arrives on the *next* bclk rise. The bit sampled at the change rise belongs to the previous word and is discarded.
  - SHIFT:
    - Each bclk rise: `shreg` ← {shreg[SAMPLE_W-2:0], sd_s}, `cnt`++.
    - On the rise where `cnt` = SAMPLE_W-1:
      - `sample_out` ← {shreg[SAMPLE_W-2:0], sd_s}, `sample_right` ← `chan`.
      - Pulse `sample_valid`, invert `lr_toggle`, go to HOLD.
  - HOLD:
    - Ignores bits (padding for 24/32-bit slots).
    - On a ws change: capture `chan`, clear `cnt`, go to SHIFT.
- Early ws change in SHIFT (before SAMPLE_W bits):
  - Discard the partial word and pulse `frame_err`.
  - Capture the new `chan`, clear `cnt`, stay in SHIFT.
  - `sample_out`, `sample_valid` and `lr_toggle` are unaffected.
- A ws change coincident with the final bit (`cnt` = SAMPLE_W-1) is an early change: the word is discarded.
- No bclk activity: state and outputs hold indefinitely.

## Timing
- Reset values:
  - `sample_out` = 0, `sample_right` = 0, `sample_valid` = 0, `lr_toggle` = 0, `frame_err` = 0.
  - State = WAIT_WS, `cnt` = 0, `shreg` = 0, `ws_prev` = 0.
- Reset asserted mid-word: next cycle is in WAIT_WS. The first word after reset is never emitted partially.
- Pin-to-edge latency: a bclk rising pin edge produces `bclk_rise` SYNC_STAGES+1 clk cycles later.
- Output update: `sample_out`, `sample_right`, `sample_valid` and the `lr_toggle` inversion all register on the clk edge after the `bclk_rise` cycle of the final bit.
- `sample_out` is stable ≥ 8 bclk periods before it can change again, covering the filter's 2-flop edge detect and capture.
- `sample_valid` and `frame_err` are never high simultaneously.

## Structure
- Shared package `audio_pkg`:
  - `i2s_rx_state_t` enum {WAIT_WS, SHIFT, HOLD}.
  - `AUDIO_SAMPLE_W` = 16, used as the default for `SAMPLE_W` here and by downstream filters.
- Sub-module `bit_sync`:
  - Parameter `STAGES`, ports `clk`, `reset`, `d`, `q`.
  - Instantiated three times. The bclk edge detector lives in the top level.

## Test plan
- Reset, then a ws change followed by 16 bits of 0x8001 on the left channel -> `sample_out` = 0x8001, `sample_right` = 0, one `sample_valid` pulse, `lr_toggle` 0→1.
- Right-channel word 0x7FFF in a 32-bit slot with padding bits = 1 -> `sample_out` = 0x7FFF, `sample_right` = 1, padding ignored, `lr_toggle` toggles once.
- Bits arriving before the first ws change after reset -> no `sample_valid`. The first valid word after the change is decoded correctly.
- ws changes after 10 bits -> one `frame_err` pulse, `sample_out` unchanged, the following full word 0x1234 is decoded.
- Reset asserted at bit 8 of a word -> all outputs 0 next cycle, that word is never emitted.
- Connected to the biquad filter with b0 = 0x4000 and other coefficients 0, stream of 0x1000 -> filter output 0x1000 once per word.
